// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO read-side control logic.
package fifo_ctrl_pkg;

  // Read scheduler states: wait for work, strobe the FIFO, take the word.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // Width of the per-grant beat counter (BURST_MAX tops out at 15).
  localparam int BEAT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set req at or after rr_ptr,
// wrapping modulo NUM_REQ, returned as a one-hot vector.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant_next
);

  // One extra bit so rr_ptr + offset can exceed NUM_REQ-1 before the wrap.
  localparam int IW = PTR_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  // Scan from rr_ptr upward and keep only the first hit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path infers a latch.
    grant_next = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      if (enable && !found && req[idx[PTR_W-1:0]]) begin
        grant_next[idx[PTR_W-1:0]] = 1'b1;
        found                      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler for the async FIFO: shares the read port among
// NUM_REQ consumers round-robin, one word in flight at a time, with each
// grant bounded to BURST_MAX words.
//
// A reset that lands while a word is in flight discards that word; the FIFO
// read pointer has already moved past it, so it is lost by design.
module fifo_rd_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_out,
  output logic                  rd_en,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic                  out_last,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t                  state, state_d;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_d;
  logic [BEAT_W-1:0]       beat_cnt, beat_cnt_d, beat_inc;
  logic                    rd_en_d, out_last_d, busy_d;
  logic [NUM_REQ-1:0]      grant_d, out_valid_d, arb_grant;
  logic [DATA_WIDTH-1:0]   out_data_d;
  logic [PTR_W-1:0]        owner, owner_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .enable     ((state == IDLE) && !fifo_empty),
    .grant_next (arb_grant)
  );

  // Encode the one-hot owner to an index and compute the next pointer.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner = PTR_W'(i);
      end
    end
    owner_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
  end

  assign beat_inc = beat_cnt + BEAT_W'(1);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    beat_cnt_d  = beat_cnt;
    grant_d     = grant;
    busy_d      = busy;
    out_data_d  = out_data;
    rd_en_d     = 1'b0;
    out_valid_d = '0;
    out_last_d  = 1'b0;
    case (state)
      IDLE: begin
        if (|arb_grant) begin
          grant_d    = arb_grant;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
          rd_en_d    = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = fifo_out;
        out_valid_d = grant;
        beat_cnt_d  = beat_inc;
        // The empty flag already reflects the read just completed.
        if ((beat_inc < BEAT_W'(BURST_MAX)) && |(req & grant) && !fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = READ;
        end else begin
          grant_d    = '0;
          busy_d     = 1'b0;
          rr_ptr_d   = owner_next;
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      rd_en     <= 1'b0;
      grant     <= '0;
      out_data  <= '0;
      out_valid <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      beat_cnt  <= beat_cnt_d;
      rd_en     <= rd_en_d;
      grant     <= grant_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: cycle-by-cycle vector table for a single
// requester, then directed sequences for the multi-cycle corner cases.
module tb_fifo_rd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_MAX  = 4;

  logic                  rd_clk   = 1'b0;
  logic                  rd_rst_n = 1'b0;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_out = '0;
  logic                  rd_en;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_REQ-1:0]    out_valid;
  logic                  out_last;
  logic                  busy;

  fifo_rd_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_MAX  (BURST_MAX)
  ) dut (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .fifo_empty (fifo_empty),
    .fifo_out   (fifo_out),
    .rd_en      (rd_en),
    .req        (req),
    .grant      (grant),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 rd_clk = ~rd_clk;

  // Simple FIFO read port: data appears the cycle after rd_en.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  int         underflow = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rd_clk) begin
    if (rd_en) begin
      if (fifo_empty) underflow <= underflow + 1;
      fifo_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  // Monitor: log every delivered word, count reads, watch grant behaviour.
  typedef struct packed {
    logic [NUM_REQ-1:0]    v;
    logic [DATA_WIDTH-1:0] d;
    logic                  l;
  } beat_t;

  beat_t              log_q[$];
  int                 rd_cnt = 0;
  int                 viol   = 0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  always @(negedge rd_clk) begin
    if (out_valid != '0) log_q.push_back('{out_valid, out_data, out_last});
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if ((prev_grant != '0 && grant != '0 && grant != prev_grant) || ($countones(grant) > 1))
      viol <= viol + 1;
    prev_grant <= grant;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    @(negedge rd_clk);
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  task automatic check_beat(input string name, input int idx, input beat_t exp);
    beat_t act;
    act = (idx < log_q.size()) ? log_q[idx] : '0;
    check(name, 64'(act), 64'(exp));
  endtask

  typedef struct {
    logic [NUM_REQ-1:0]    req;
    logic                  rd_en;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  busy;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, rd0;
    logic [NUM_REQ-1:0] rr_own [3];

    // Single requester, 8 words, BURST_MAX=4: two bursts split by one IDLE cycle.
    //            req      rd grant    valid    data  last busy
    vecs[0]  = '{4'b0001, 1, 4'b0001, 4'b0000, 8'h00, 0, 1};
    vecs[1]  = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h00, 0, 1};
    vecs[2]  = '{4'b0001, 1, 4'b0001, 4'b0001, 8'h00, 0, 1};
    vecs[3]  = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h00, 0, 1};
    vecs[4]  = '{4'b0001, 1, 4'b0001, 4'b0001, 8'h01, 0, 1};
    vecs[5]  = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h01, 0, 1};
    vecs[6]  = '{4'b0001, 1, 4'b0001, 4'b0001, 8'h02, 0, 1};
    vecs[7]  = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h02, 0, 1};
    vecs[8]  = '{4'b0001, 0, 4'b0000, 4'b0001, 8'h03, 1, 0};
    vecs[9]  = '{4'b0001, 1, 4'b0001, 4'b0000, 8'h03, 0, 1};
    vecs[10] = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h03, 0, 1};
    vecs[11] = '{4'b0001, 1, 4'b0001, 4'b0001, 8'h04, 0, 1};
    vecs[12] = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h04, 0, 1};
    vecs[13] = '{4'b0001, 1, 4'b0001, 4'b0001, 8'h05, 0, 1};
    vecs[14] = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h05, 0, 1};
    vecs[15] = '{4'b0001, 1, 4'b0001, 4'b0001, 8'h06, 0, 1};
    vecs[16] = '{4'b0001, 0, 4'b0001, 4'b0000, 8'h06, 0, 1};
    vecs[17] = '{4'b0001, 0, 4'b0000, 4'b0001, 8'h07, 1, 0};
    vecs[18] = '{4'b0001, 0, 4'b0000, 4'b0000, 8'h07, 0, 0};
    vecs[19] = '{4'b0001, 0, 4'b0000, 4'b0000, 8'h07, 0, 0};

    rr_own[0] = 4'b0001;
    rr_own[1] = 4'b0010;
    rr_own[2] = 4'b1000;

    // Reset values.
    rd_rst_n = 1'b0;
    repeat (2) @(negedge rd_clk);
    check("reset rd_en", 64'(rd_en), 64'(0));
    check("reset grant", 64'(grant), 64'(0));
    check("reset out_data", 64'(out_data), 64'(0));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_last", 64'(out_last), 64'(0));
    check("reset busy", 64'(busy), 64'(0));

    // Single requester, table-driven.
    for (int i = 0; i < 8; i++) load(8'(i));
    rd_rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      req = vecs[k].req;
      @(negedge rd_clk);
      check($sformatf("single vec[%0d] {rd,grant,valid,data,last,busy}", k),
            64'({rd_en, grant, out_valid, out_data, out_last, busy}),
            64'({vecs[k].rd_en, vecs[k].grant, vecs[k].valid, vecs[k].data,
                 vecs[k].last, vecs[k].busy}));
    end
    req = '0;

    // Round-robin: 12 words, req=1011 from rr_ptr=0 -> owners 0,1,3.
    do_reset();
    base = log_q.size();
    rd0  = rd_cnt;
    for (int i = 0; i < 12; i++) load(8'(i));
    req = 4'b1011;
    repeat (40) @(negedge rd_clk);
    req = '0;
    check("rr beat count", 64'(log_q.size() - base), 64'(12));
    check("rr rd_en count", 64'(rd_cnt - rd0), 64'(12));
    for (int i = 0; i < 12; i++)
      check_beat($sformatf("rr beat %0d", i), base + i,
                 '{rr_own[i / 4], 8'(i), (i % 4) == 3});

    // Empty mid-burst: 2 words for consumer 2.
    do_reset();
    base = log_q.size();
    rd0  = rd_cnt;
    load(8'h20);
    load(8'h21);
    req = 4'b0100;
    repeat (20) @(negedge rd_clk);
    check("empty beat count", 64'(log_q.size() - base), 64'(2));
    check("empty rd_en count", 64'(rd_cnt - rd0), 64'(2));
    check_beat("empty beat 0", base, '{4'b0100, 8'h20, 1'b0});
    check_beat("empty beat 1", base + 1, '{4'b0100, 8'h21, 1'b1});
    check("empty end {grant,busy}", 64'({grant, busy}), 64'(0));
    req = '0;

    // Request drop during the READ cycle of beat 2.
    do_reset();
    base = log_q.size();
    rd0  = rd_cnt;
    for (int i = 0; i < 4; i++) load(8'h30 + 8'(i));
    req = 4'b0010;
    repeat (3) @(negedge rd_clk);
    check("drop in READ {rd,valid,data}", 64'({rd_en, out_valid, out_data}),
          64'({1'b1, 4'b0010, 8'h30}));
    req = '0;
    repeat (10) @(negedge rd_clk);
    check("drop beat count", 64'(log_q.size() - base), 64'(2));
    check("drop rd_en count", 64'(rd_cnt - rd0), 64'(2));
    check_beat("drop beat 0", base, '{4'b0010, 8'h30, 1'b0});
    check_beat("drop beat 1", base + 1, '{4'b0010, 8'h31, 1'b1});
    check("drop end {grant,busy}", 64'({grant, busy}), 64'(0));

    // Reset during CAPTURE: FIFO holds 32,33 then 40,41,42; 32 is in flight.
    do_reset();
    load(8'h40);
    load(8'h41);
    load(8'h42);
    req = 4'b0100;
    repeat (2) @(negedge rd_clk);
    check("rst pre {busy,grant,rd}", 64'({busy, grant, rd_en}), 64'({1'b1, 4'b0100, 1'b0}));
    rd_rst_n = 1'b0;
    #1;
    check("rst async outputs", 64'({rd_en, grant, out_valid, out_data, out_last, busy}), 64'(0));
    req  = 4'b0010;
    base = log_q.size();
    rd0  = rd_cnt;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    repeat (20) @(negedge rd_clk);
    check("rst beat count", 64'(log_q.size() - base), 64'(4));
    check("rst rd_en count", 64'(rd_cnt - rd0), 64'(4));
    check_beat("rst beat 0", base, '{4'b0010, 8'h33, 1'b0});
    check_beat("rst beat 1", base + 1, '{4'b0010, 8'h40, 1'b0});
    check_beat("rst beat 2", base + 2, '{4'b0010, 8'h41, 1'b0});
    check_beat("rst beat 3", base + 3, '{4'b0010, 8'h42, 1'b1});
    req = '0;

    // Idle with an empty FIFO and every consumer requesting.
    req = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      @(negedge rd_clk);
      check($sformatf("idle empty cycle %0d {rd,grant,busy}", c),
            64'({rd_en, grant, busy}), 64'(0));
    end
    req = '0;

    @(negedge rd_clk);
    check("grant switch/one-hot violations", 64'(viol), 64'(0));
    check("rd_en while empty", 64'(underflow), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Read-side scheduler for the async FIFO. Runs in the read clock domain and shares the FIFO read port among NUM_REQ consumers.
- Selects consumers round-robin, issues single-cycle rd_en pulses and captures fifo_out.
- Routes each word to the granted consumer with a one-hot valid.
- Bounds each grant to BURST_MAX words so no consumer starves the others.

Parameters:
- NUM_REQ, 4, number of consumers (2..8)
- DATA_WIDTH, 8, FIFO word width
- BURST_MAX, 4, maximum words per grant (1..15)

Ports:
- rd_clk  in  1  read-domain clock (same clock as the FIFO read port)
- rd_rst_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_out  in  DATA_WIDTH  FIFO read data, valid the cycle after rd_en
- rd_en  out  1  FIFO read strobe
- req  in  NUM_REQ  per-consumer read request, level
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- out_data  out  DATA_WIDTH  delivered word
- out_valid  out  NUM_REQ  one-hot, 1-cycle pulse to the owning consumer
- out_last  out  1  high with the final out_valid of a grant
- busy  out  1  grant active

Behaviour:
- Clock and reset: one clock, rd_clk. Reset is asynchronous and active-low, on rd_rst_n.
- Reset values: rd_en=0, grant=0, out_data=0, out_valid=0, out_last=0, busy=0, state=IDLE, rr_ptr=0, beat_cnt=0.
- All outputs are registered.
- States: IDLE, READ, CAPTURE.
- IDLE:
  - If any req bit is set and fifo_empty=0, pick the first set req at or after rr_ptr, wrapping modulo NUM_REQ.
  - Set grant to that one-hot, busy=1, beat_cnt=0, and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - rd_en=1 for exactly this one cycle, then go to CAPTURE.
  - Entry into READ is only allowed when fifo_empty=0 on the deciding edge.
- CAPTURE:
  - Register out_data=fifo_out and pulse out_valid=grant for one cycle. beat_cnt increments.
  - Only one read is in flight at a time. Peak throughput is 1 word per 2 cycles, which guarantees the empty flag reflects the previous read before the next decision.
- Decision at the end of CAPTURE:
  - Continue to READ only if beat_cnt+1 < BURST_MAX, req[owner] is still 1, and fifo_empty=0.
  - Otherwise release: grant=0, busy=0, rr_ptr=owner+1 (wrapping NUM_REQ-1 to 0), go to IDLE.
  - out_last=1 with the valid pulse when the grant is released.
- req deasserted while in READ: the in-flight word is still captured and delivered to that owner, then the grant is released. No data is dropped.
- fifo_empty rises mid-burst: finish the in-flight word, then release with out_last=1.
- Minimum gap: one IDLE cycle between grants, so grant never switches owner without passing through 0.
- Single requester with continuous data: re-granted after one IDLE cycle. Fairness still holds because rr_ptr advances.
- Reset mid-operation: everything returns to reset values immediately, including a pending word, which is discarded. The FIFO pointer has already advanced; loss of that word is accepted and documented.
- rd_en is never asserted while fifo_empty=1 was sampled on the deciding edge, so no underflow.
- Widths:
  - beat_cnt is 4 bits.
  - rr_ptr is clog2(NUM_REQ) bits, with explicit wrap at NUM_REQ-1 for non-power-of-2 NUM_REQ.

Decomposition:
- Shared package fifo_ctrl_pkg holds the state enumeration (IDLE, READ, CAPTURE) and the width constants.
- Sub-module rr_arbiter: combinational round-robin select taking req, rr_ptr and enable, producing a one-hot grant_next.

Test Plan:
- Single requester: load the FIFO with 0x00..0x07, BURST_MAX=4, req=4'b0001 held. Expect rd_en pulses every 2 cycles. out_valid[0] carries 00,01,02,03 with out_last on 03, one IDLE cycle, then 04..07 with out_last on 07, then grant=0.
- Round-robin: 12 words loaded, req=4'b1011 held, rr_ptr=0. Expect grants in order 0,1,3, each receiving 4 words: consumer 0 gets 00–03, consumer 1 gets 04–07, consumer 3 gets 08–0B.
- Empty mid-burst: load 2 words, req[2]=1. Expect 2 valids, out_last on the second, no third rd_en, busy falls.
- Request drop: req[1] falls in the READ cycle of beat 2. Expect that word still delivered with out_valid[1] and out_last=1, then grant released.
- Reset mid-burst: pull rd_rst_n low during CAPTURE. Expect all outputs 0 immediately. After release with req=4'b0010, arbitration restarts from rr_ptr=0 and consumer 1 is granted next.
- Idle empty: fifo_empty=1 with req=4'b1111 held for 50 cycles. Expect rd_en=0, grant=0 and busy=0 throughout.
